// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding-select and load-use hazard control for a 5-stage MIPS pipeline.
// Optional saturating stall counter enabled by defining STALL_COUNT_EN.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              IdValid,
  input  logic [REG_AW-1:0] IdRs,
  input  logic [REG_AW-1:0] IdRt,
  input  logic              IdUsesRt,
  input  logic [REG_AW-1:0] IdDst,
  input  logic              IdRegWrite,
  input  logic              IdMemRead,
  input  logic              Flush,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              Stall,
  output logic              Bubble
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0]       StallCount
`endif
);

  localparam int unsigned NUM_STAGES = 3;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned EX_IDX     = 0;
  localparam int unsigned MEM_IDX    = 1;
  localparam int unsigned WB_IDX     = 2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dst;
    logic              rw;
    logic              mr;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  stage_t     stage_q [NUM_STAGES];
  stage_t     stage_d [NUM_STAGES];
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;
  logic       bubble_q, bubble_d;
  logic       ex_load_hit_c;
  logic       stall_c;
  logic       issue_c;

  // A stage produces register r only for a live, writing instruction and never for r0.
  function automatic logic writes_reg(input stage_t s, input logic [REG_AW-1:0] r);
    return s.v && s.rw && (s.dst == r) && (r != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input stage_t ex_s, input stage_t mem_s,
                                         input logic [REG_AW-1:0] r);
    logic [1:0] sel;
    sel = FWD_RF;
    if (writes_reg(ex_s, r)) begin
      sel = FWD_EX;
    end else if (writes_reg(mem_s, r)) begin
      sel = FWD_MEM;
    end
    return sel;
  endfunction

  // Load in EX whose result the ID instruction needs; flush overrides the stall.
  always_comb begin
    ex_load_hit_c = 1'b0;
    stall_c       = 1'b0;
    issue_c       = 1'b0;
    if (stage_q[EX_IDX].v && stage_q[EX_IDX].mr && (stage_q[EX_IDX].dst != '0)) begin
      ex_load_hit_c = (stage_q[EX_IDX].dst == IdRs) ||
                      (IdUsesRt && (stage_q[EX_IDX].dst == IdRt));
    end
    stall_c = IdValid && !Flush && ex_load_hit_c;
    issue_c = IdValid && !Flush && !stall_c;
  end

  // Next shadow-pipeline contents and registered mux selects.
  always_comb begin
    stage_d[EX_IDX]  = STAGE_BUBBLE;
    stage_d[MEM_IDX] = stage_q[EX_IDX];
    stage_d[WB_IDX]  = stage_q[MEM_IDX];
    fwd_a_d          = FWD_RF;
    fwd_b_d          = FWD_RF;
    bubble_d         = 1'b1;
    if (issue_c) begin
      stage_d[EX_IDX].v   = 1'b1;
      stage_d[EX_IDX].dst = IdDst;
      stage_d[EX_IDX].rw  = IdRegWrite;
      stage_d[EX_IDX].mr  = IdMemRead;
      bubble_d            = 1'b0;
      fwd_a_d             = fwd_sel(stage_q[EX_IDX], stage_q[MEM_IDX], IdRs);
      if (IdUsesRt) begin
        fwd_b_d = fwd_sel(stage_q[EX_IDX], stage_q[MEM_IDX], IdRt);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        stage_q[i] <= STAGE_BUBBLE;
      end
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
      bubble_q <= 1'b1;
    end else begin
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        stage_q[i] <= stage_d[i];
      end
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      bubble_q <= bubble_d;
    end
  end

  assign ForwardA = fwd_a_q;
  assign ForwardB = fwd_b_q;
  assign Bubble   = bubble_q;
  assign Stall    = stall_c;

`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed self-checking bench for fwd_hazard_ctrl: forwarding, load-use stall, r0, flush, reset.
module tb_fwd_hazard_ctrl;

  logic       Clk;
  logic       Rst;
  logic       IdValid;
  logic [4:0] IdRs;
  logic [4:0] IdRt;
  logic       IdUsesRt;
  logic [4:0] IdDst;
  logic       IdRegWrite;
  logic       IdMemRead;
  logic       Flush;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       Stall;
  logic       Bubble;
`ifdef STALL_COUNT_EN
  logic [15:0] StallCount;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  fwd_hazard_ctrl #(.REG_AW(5)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .IdValid    (IdValid),
    .IdRs       (IdRs),
    .IdRt       (IdRt),
    .IdUsesRt   (IdUsesRt),
    .IdDst      (IdDst),
    .IdRegWrite (IdRegWrite),
    .IdMemRead  (IdMemRead),
    .Flush      (Flush),
    .ForwardA   (ForwardA),
    .ForwardB   (ForwardB),
    .Stall      (Stall),
    .Bubble     (Bubble)
`ifdef STALL_COUNT_EN
    ,
    .StallCount (StallCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one ID-stage instruction (called just after a falling edge).
  task automatic drive(input int v, input int rs, input int rt, input int uses,
                       input int dst, input int rw, input int mr, input int fl);
    IdValid    = 1'(v);
    IdRs       = 5'(rs);
    IdRt       = 5'(rt);
    IdUsesRt   = 1'(uses);
    IdDst      = 5'(dst);
    IdRegWrite = 1'(rw);
    IdMemRead  = 1'(mr);
    Flush      = 1'(fl);
    #1;
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask

  initial begin
    Rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check("rst_fwd_a", 16'(ForwardA), 16'h0);
    check("rst_fwd_b", 16'(ForwardB), 16'h0);
    check("rst_bubble", 16'(Bubble), 16'h1);
    check("rst_stall", 16'(Stall), 16'h0);
`ifdef STALL_COUNT_EN
    check("rst_cnt", StallCount, 16'h0);
`endif
    Rst = 1'b0;

    // EX/MEM forwarding: add r3, then sub r?,r3,r4
    drive(1, 1, 2, 1, 3, 1, 0, 0);
    step();
    check("add_in_ex_bubble", 16'(Bubble), 16'h0);
    drive(1, 3, 4, 1, 10, 1, 0, 0);
    check("exfwd_stall", 16'(Stall), 16'h0);
    step();
    check("exfwd_a", 16'(ForwardA), 16'h2);
    check("exfwd_b", 16'(ForwardB), 16'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("idle_bubble", 16'(Bubble), 16'h1);
    check("idle_fwd_a", 16'(ForwardA), 16'h0);
    drain();

    // MEM/WB forwarding on operand B
    drive(1, 1, 2, 1, 5, 1, 0, 0);
    step();
    drive(1, 1, 2, 1, 6, 1, 0, 0);
    step();
    drive(1, 12, 5, 1, 11, 1, 0, 0);
    check("memfwd_stall", 16'(Stall), 16'h0);
    step();
    check("memfwd_b", 16'(ForwardB), 16'h1);
    check("memfwd_a", 16'(ForwardA), 16'h0);
    drain();

    // Newest producer wins; Rt ignored when not used
    drive(1, 1, 2, 1, 7, 1, 0, 0);
    step();
    drive(1, 1, 2, 1, 7, 1, 0, 0);
    step();
    drive(1, 7, 7, 0, 16, 1, 0, 0);
    step();
    check("prio_a", 16'(ForwardA), 16'h2);
    check("prio_b_unused", 16'(ForwardB), 16'h0);
    drain();

    // Load-use: one stall cycle then MEM forwarding
    drive(1, 1, 2, 0, 8, 1, 1, 0);
    step();
    drive(1, 8, 9, 1, 12, 1, 0, 0);
    check("lu_stall", 16'(Stall), 16'h1);
    step();
    check("lu_bubble", 16'(Bubble), 16'h1);
    check("lu_bubble_fwd_a", 16'(ForwardA), 16'h0);
    check("lu_stall_released", 16'(Stall), 16'h0);
`ifdef STALL_COUNT_EN
    check("lu_cnt", StallCount, 16'h1);
`endif
    step();
    check("lu_fwd_a", 16'(ForwardA), 16'h1);
    check("lu_fwd_b", 16'(ForwardB), 16'h0);
    check("lu_consumer_live", 16'(Bubble), 16'h0);
    drain();

    // r0 never forwards or stalls, even from a load
    drive(1, 1, 2, 0, 0, 1, 1, 0);
    step();
    drive(1, 0, 0, 1, 13, 1, 0, 0);
    check("r0_stall", 16'(Stall), 16'h0);
    step();
    check("r0_fwd_a", 16'(ForwardA), 16'h0);
    check("r0_fwd_b", 16'(ForwardB), 16'h0);
    check("r0_bubble", 16'(Bubble), 16'h0);
    drain();

    // Flush beats a load-use stall
    drive(1, 1, 2, 0, 9, 1, 1, 0);
    step();
    drive(1, 9, 0, 0, 14, 1, 0, 1);
    check("flush_stall", 16'(Stall), 16'h0);
    step();
    check("flush_bubble", 16'(Bubble), 16'h1);
    check("flush_fwd_a", 16'(ForwardA), 16'h0);
    drain();

    // Back-to-back loads, each load-use pair stalls on its own
    drive(1, 1, 2, 0, 13, 1, 1, 0);
    step();
    drive(1, 13, 0, 0, 14, 1, 1, 0);
    check("b2b_stall1", 16'(Stall), 16'h1);
    step();
    check("b2b_bubble1", 16'(Bubble), 16'h1);
    check("b2b_nostall1", 16'(Stall), 16'h0);
    step();
    check("b2b_fwd1", 16'(ForwardA), 16'h1);
    drive(1, 3, 14, 1, 15, 1, 0, 0);
    check("b2b_stall2", 16'(Stall), 16'h1);
    step();
    check("b2b_bubble2", 16'(Bubble), 16'h1);
    step();
    check("b2b_fwd2_b", 16'(ForwardB), 16'h1);
    check("b2b_fwd2_a", 16'(ForwardA), 16'h0);
`ifdef STALL_COUNT_EN
    check("b2b_cnt", StallCount, 16'h3);
`endif
    drain();

    // Reset asserted in the stall cycle drops the stall
    drive(1, 1, 2, 0, 15, 1, 1, 0);
    step();
    drive(1, 15, 15, 1, 17, 1, 0, 0);
    check("rs_stall_before", 16'(Stall), 16'h1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    #1;
    check("rs_fwd_a", 16'(ForwardA), 16'h0);
    check("rs_fwd_b", 16'(ForwardB), 16'h0);
    check("rs_bubble", 16'(Bubble), 16'h1);
    check("rs_stall", 16'(Stall), 16'h0);
`ifdef STALL_COUNT_EN
    check("rs_cnt", StallCount, 16'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Control block for the EX-stage operand muxes of the 5-stage MIPS pipeline. It drives the 2-bit select inputs of the two 3:1 forwarding muxes (ALU operand A and operand B).
- Keeps its own shadow pipeline of destination-register/control info for the EX, MEM and WB stages.
- Detects load-use hazards, stalls IF/ID for one cycle and inserts a bubble into EX.
- Selects are computed in ID and registered, so they are valid during the cycle the instruction sits in EX.

Parameters:
REG_AW, 5, register-address width.

Ports:
Clk  input  1  pipeline clock, rising edge.
Rst  input  1  synchronous, active-high reset.
IdValid  input  1  ID stage holds a real instruction.
IdRs  input  REG_AW  source register 1 of the ID instruction.
IdRt  input  REG_AW  source register 2 of the ID instruction.
IdUsesRt  input  1  ID instruction reads Rt as an operand (R-type, store, branch).
IdDst  input  REG_AW  destination register of the ID instruction.
IdRegWrite  input  1  ID instruction writes the register file.
IdMemRead  input  1  ID instruction is a load.
Flush  input  1  taken branch/jump: squash the ID instruction.
ForwardA  output  2  operand-A mux select for the EX instruction.
ForwardB  output  2  operand-B mux select for the EX instruction.
Stall  output  1  hold PC and IF/ID; combinational.
Bubble  output  1  registered; the EX-stage slot is a bubble.

Behaviour:
- Select encoding: 00 = register-file value; 01 = MEM/WB result; 10 = EX/MEM ALU result; 11 is never driven.
- Shadow stages: EX, MEM and WB each hold {v, dst, rw, mr}. A stage "writes r" when v=1, rw=1, dst=r and r!=0.
- Stall is combinational and asserts when all of these hold:
  - IdValid=1 and Flush=0;
  - EX.v=1, EX.mr=1, EX.dst!=0;
  - EX.dst==IdRs, or (IdUsesRt=1 and EX.dst==IdRt).
- Every posedge with Rst=0:
  - WB<=MEM and MEM<=EX, unconditionally.
  - EX<=bubble (v=0, rw=0, mr=0, dst=0) if Stall=1, Flush=1 or IdValid=0.
  - Otherwise EX<={1, IdDst, IdRegWrite, IdMemRead}.
  - Bubble<= inverse of the new EX.v.
- ForwardA is registered from IdRs, evaluated against the pre-edge EX and MEM stages:
  - EX writes IdRs -> 10 (newest producer wins);
  - else MEM writes IdRs -> 01;
  - else 00.
- ForwardB: same rule on IdRt. It is forced to 00 when IdUsesRt=0.
- When EX is loaded with a bubble, ForwardA and ForwardB load 00.
- Load-use latency: the stall lasts exactly 1 cycle. On the following cycle the load sits in MEM, so the dependent instruction gets select 01 when it reaches EX.
- Register 0 never causes forwarding or a stall.
- Flush and a stall condition in the same cycle: Flush wins; Stall=0; bubble inserted.
- Back-to-back loads feeding a consumer: each load-use pair stalls independently.
- Reset: all shadow stages cleared to bubble; ForwardA=00, ForwardB=00, Bubble=1; Stall=0 (EX is empty).
- Rst asserted mid-stall: reset takes priority and the pending stall is dropped.

Optional Feature:
STALL_COUNT_EN
- Defined:
  - Adds output StallCount (16 bits).
  - Incremented on every posedge where Stall=1; saturates at 16'hFFFF.
  - Cleared by Rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Forward from EX/MEM:
  - Issue add r3 (dst=3, rw=1), then sub with IdRs=3, IdRt=4, IdUsesRt=1.
  - Required: cycle the sub is in EX, ForwardA=10, ForwardB=00, no Stall.
- Forward from MEM/WB:
  - Producer dst=5, one independent instruction, then consumer with IdRt=5, IdUsesRt=1.
  - Required: ForwardB=01, ForwardA=00.
- Priority:
  - Two consecutive writers of r7, then consumer with IdRs=7.
  - Required: ForwardA=10 (newest producer), not 01.
- Load-use:
  - lw dst=8 (mr=1), then consumer with IdRs=8.
  - Required: Stall=1 for exactly 1 cycle; Bubble=1 the next cycle; consumer then reaches EX with ForwardA=01.
  - With STALL_COUNT_EN: StallCount increments 0->1.
- Register 0 and Flush:
  - Writer with dst=0, then consumer with IdRs=0 -> ForwardA=00.
  - lw dst=9 followed by a dependent instruction with Flush=1 -> Stall=0, Bubble=1.
- Reset mid-stall:
  - Assert Rst in the cycle Stall=1.
  - Required: next cycle ForwardA=00, ForwardB=00, Bubble=1, Stall=0.
